// File: rtl/commit_unit_pkg.sv
// r2rv_pkg: shared buffer-entry types, commit FSM states and tag helpers
package r2rv_pkg;
  localparam int BUF_SIZE_LOG = 4;
  localparam int BUF_SIZE = 2 ** BUF_SIZE_LOG;
  localparam int TW = BUF_SIZE_LOG + 1;
  localparam int MAX_TAG = 2 * BUF_SIZE - 1;
  typedef logic [TW-1:0] tag_t;
  typedef enum logic [1:0] {S_EMPTY, S_ISSUED, S_EXECUTING, S_EXECUTED} state;
  typedef enum logic [1:0] {U_ALU, U_BRANCH, U_LOAD, U_STORE} unit;
  typedef enum logic [2:0] {M_BYTE, M_HALF, M_WORD, M_BYTEU, M_HALFU} ldst_mode;
  typedef enum logic [1:0] {X_ADD, X_SUB, X_AND, X_OR} ex_mode;
  typedef enum logic {C_RUN, C_STORE_WAIT} commit_state;
  typedef struct packed {
    tag_t        tag;
    state        e_state;
    logic [5:0]  speculative_tag;
    unit         Unit;
    ex_mode      ex;
    logic [4:0]  Dest;
    logic [31:0] result;
    logic [31:0] A;
    logic [31:0] Vk;
    ldst_mode    rwmm;
  } entry;
  // Tags live in 1..MAX_TAG; tag 0 is reserved for "no entry", so wrap skips it
  function automatic tag_t tag_add(tag_t t, logic [1:0] k);
    logic [TW:0] s;
    s = {1'b0, t} + {{(TW-1){1'b0}}, k};
    return (s > (TW+1)'(MAX_TAG)) ? tag_t'(s - (TW+1)'(MAX_TAG)) : tag_t'(s);
  endfunction
  function automatic logic rf_writes(entry e);
    return e.Dest != '0 && e.Unit != U_STORE && e.Unit != U_BRANCH;
  endfunction
endpackage

// File: rtl/commit_unit_if.sv
// commit_unit_if: buffer snapshot in, commit/register-file/store-port signals out
interface commit_unit_if;
  import r2rv_pkg::*;
  entry [BUF_SIZE-1:0] entries;
  logic [1:0] is_really_commited;
  logic [1:0] is_commited_store;
  tag_t [1:0] commited_tags;
  logic [1:0] rf_we;
  logic [1:0][4:0] rf_addr;
  logic [1:0][31:0] rf_data;
  logic mem_wvalid;
  logic mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  ldst_mode mem_wmode;
  modport master (
    input  entries, mem_wready,
    output is_really_commited, is_commited_store, commited_tags,
           rf_we, rf_addr, rf_data, mem_wvalid, mem_waddr, mem_wdata, mem_wmode
  );
  modport slave (
    output entries, mem_wready,
    input  is_really_commited, is_commited_store, commited_tags,
           rf_we, rf_addr, rf_data, mem_wvalid, mem_waddr, mem_wdata, mem_wmode
  );
endinterface

// File: rtl/commit_unit_lookup.sv
// commit_lookup: finds the unique buffer entry carrying a tag and reports if it may retire
module commit_lookup
  import r2rv_pkg::*;
(
  input  entry [BUF_SIZE-1:0]     entries_i,
  input  tag_t                    tag_i,
  output logic                    hit_o,
  output logic                    ready_o,
  output logic [BUF_SIZE_LOG-1:0] idx_o,
  output entry                    e_o
);
  logic [TW-1:0] cnt;
  // count matches; an ambiguous tag is treated as absent
  always_comb begin
    cnt = '0;
    idx_o = '0;
    for (int i = 0; i < BUF_SIZE; i++)
      if (entries_i[i].tag == tag_i) begin
        cnt = cnt + TW'(1);
        idx_o = BUF_SIZE_LOG'(i);
      end
  end
  assign hit_o = cnt == TW'(1);
  assign e_o = entries_i[idx_o];
  assign ready_o = hit_o & e_o.e_state == S_EXECUTED & e_o.speculative_tag == '0;
endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement of up to two ops per cycle with a blocking store port
module commit_unit
  import r2rv_pkg::*;
(
  input logic clk,
  input logic reset,
  commit_unit_if.master bus
);
  commit_state state_q, state_d;
  tag_t head_q, head_d, tag1;
  logic hit0, hit1, rdy0, rdy1, ret0, ret1, st_go, st_done;
  logic [BUF_SIZE_LOG-1:0] idx0, idx1;
  entry e0, e1;
  logic [1:0] n, rc_d, rc_q, st_d, st_q, we_d, we_q;
  tag_t [1:0] tags_d, tags_q;
  logic [1:0][4:0] addr_d, addr_q;
  logic [1:0][31:0] data_d, data_q;
  logic [31:0] a_q, vk_q;
  ldst_mode mode_q;
  logic unused;
  assign tag1 = tag_add(head_q, 2'd1);
  commit_lookup u_lk0 (.entries_i(bus.entries), .tag_i(head_q), .hit_o(hit0), .ready_o(rdy0), .idx_o(idx0), .e_o(e0));
  commit_lookup u_lk1 (.entries_i(bus.entries), .tag_i(tag1), .hit_o(hit1), .ready_o(rdy1), .idx_o(idx1), .e_o(e1));
  // FSM state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= C_RUN;
    else state_q <= state_d;
  // a ready head store parks the FSM until memory accepts it
  always_comb state_d = st_go ? C_STORE_WAIT : st_done ? C_RUN : state_q;
  // FSM outputs: retirement decisions and store request; a store blocks slot 1
  always_comb begin
    bus.mem_wvalid = state_q == C_STORE_WAIT;
    st_done = state_q == C_STORE_WAIT & bus.mem_wready;
    ret0 = state_q == C_RUN & rdy0 & e0.Unit != U_STORE;
    st_go = state_q == C_RUN & rdy0 & e0.Unit == U_STORE;
    ret1 = ret0 & rdy1 & e1.Unit != U_STORE;
  end
  // next head tag and the values the output stage will present next cycle
  always_comb begin
    n = st_done ? 2'd1 : ret1 ? 2'd2 : {1'b0, ret0};
    head_d = tag_add(head_q, n);
    rc_d = {ret1, ret0 | st_done};
    st_d = {1'b0, st_done};
    we_d = {ret1 & rf_writes(e1), ret0 & rf_writes(e0)};
    tags_d[0] = rc_d[0] ? head_q : '0;
    tags_d[1] = ret1 ? tag1 : '0;
    addr_d[0] = we_d[0] ? e0.Dest : '0;
    addr_d[1] = we_d[1] ? e1.Dest : '0;
    data_d[0] = we_d[0] ? e0.result : '0;
    data_d[1] = we_d[1] ? e1.result : '0;
  end
  // head counter, store latch and registered commit outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head_q <= tag_t'(1);
      a_q <= '0;
      vk_q <= '0;
      mode_q <= M_BYTE;
      rc_q <= '0;
      st_q <= '0;
      we_q <= '0;
      tags_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      head_q <= head_d;
      rc_q <= rc_d;
      st_q <= st_d;
      we_q <= we_d;
      tags_q <= tags_d;
      addr_q <= addr_d;
      data_q <= data_d;
      if (st_go) begin
        a_q <= e0.A;
        vk_q <= e0.Vk;
        mode_q <= e0.rwmm;
      end
    end
  assign bus.is_really_commited = rc_q;
  assign bus.is_commited_store = st_q;
  assign bus.commited_tags = tags_q;
  assign bus.rf_we = we_q;
  assign bus.rf_addr = addr_q;
  assign bus.rf_data = data_q;
  assign bus.mem_waddr = a_q;
  assign bus.mem_wdata = vk_q;
  assign bus.mem_wmode = mode_q;
  assign unused = ^{hit0, hit1, idx0, idx1, e0, e1};
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed scenarios plus a randomized run against an in-order retirement model
module tb_commit_unit;
  import r2rv_pkg::*;
  typedef logic [90:0] obs_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  entry buf_m [BUF_SIZE];
  commit_unit_if bus();
  commit_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push();
    for (int i = 0; i < BUF_SIZE; i++) bus.entries[i] = buf_m[i];
  endtask
  task automatic clear_buf();
    for (int i = 0; i < BUF_SIZE; i++) buf_m[i] = '0;
    push();
  endtask
  task automatic put(input int slot, input int tag, input state st, input unit u, input int dest, input logic [31:0] res);
    entry e;
    e = '0;
    e.tag = tag_t'(tag);
    e.e_state = st;
    e.Unit = u;
    e.Dest = 5'(dest);
    e.result = res;
    buf_m[slot] = e;
    push();
  endtask
  function automatic obs_t snap();
    return {bus.is_really_commited, bus.is_commited_store, bus.commited_tags[1], bus.commited_tags[0],
            bus.rf_we, bus.rf_addr[1], bus.rf_addr[0], bus.rf_data[1], bus.rf_data[0], bus.mem_wvalid};
  endfunction
  function automatic obs_t mk(logic [1:0] rc, logic [1:0] st, int t1, int t0, logic [1:0] we,
                              int a1, int a0, logic [31:0] d1, logic [31:0] d0, logic wv);
    return {rc, st, tag_t'(t1), tag_t'(t0), we, 5'(a1), 5'(a0), d1, d0, wv};
  endfunction
  function automatic int wrap(int t);
    return (t - 1) % MAX_TAG + 1;
  endfunction
  // an op may retire only if its tag appears exactly once, it has executed and is non-speculative
  function automatic int find(int t);
    int hits = 0;
    int at = -1;
    for (int i = 0; i < BUF_SIZE; i++)
      if (buf_m[i].tag == tag_t'(t)) begin
        hits++;
        at = i;
      end
    if (hits != 1 || buf_m[at].e_state != S_EXECUTED || buf_m[at].speculative_tag != 0) return -1;
    return at;
  endfunction

  task automatic test_reset();
    obs_t o;
    clear_buf();
    bus.mem_wready = 1'b0;
    tick();
    tick();
    o = snap();
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
    total++;
    if ({bus.mem_waddr, bus.mem_wdata, bus.mem_wmode} !== '0) begin
      bad++; $display("FAIL reset_store_port got=%h/%h/%0d want=0", bus.mem_waddr, bus.mem_wdata, bus.mem_wmode);
    end
    reset = 1'b1;
    tick();
    o = snap();
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_empty_buf got=%h want=0", o); end
  endtask

  task automatic test_two_alu();
    obs_t o, x;
    put(0, 1, S_EXECUTED, U_ALU, 5, 32'hA);
    put(1, 2, S_EXECUTED, U_ALU, 6, 32'hB);
    tick();
    o = snap();
    x = mk(2'b11, 2'b00, 2, 1, 2'b11, 6, 5, 32'hB, 32'hA, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL two_alu got=%h want=%h", o, x); end
    clear_buf();
    tick();
    o = snap();
    total++;
    if (o !== '0) begin bad++; $display("FAIL two_alu_one_cycle got=%h want=0", o); end
  endtask

  task automatic test_partial();
    obs_t o, x;
    put(0, 3, S_EXECUTED, U_ALU, 7, 32'h33);
    put(1, 4, S_EXECUTING, U_BRANCH, 8, 32'h44);
    tick();
    o = snap();
    x = mk(2'b01, 2'b00, 0, 3, 2'b01, 0, 7, 32'h0, 32'h33, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL partial_slot0 got=%h want=%h", o, x); end
    buf_m[0] = '0;
    push();
    tick();
    o = snap();
    total++;
    if (o !== '0) begin bad++; $display("FAIL partial_wait got=%h want=0", o); end
    buf_m[1].e_state = S_EXECUTED;
    push();
    tick();
    o = snap();
    x = mk(2'b01, 2'b00, 0, 4, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL partial_branch got=%h want=%h", o, x); end
    clear_buf();
  endtask

  task automatic test_store();
    obs_t o, x;
    put(0, 5, S_EXECUTED, U_STORE, 9, 32'h55);
    buf_m[0].A = 32'h100;
    buf_m[0].Vk = 32'hDEAD;
    buf_m[0].rwmm = M_WORD;
    push();
    bus.mem_wready = 1'b0;
    tick();
    clear_buf();
    for (int c = 0; c < 3; c++) begin
      o = snap();
      x = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b1);
      total++;
      if (o !== x) begin bad++; $display("FAIL store_wait%0d got=%h want=%h", c, o, x); end
      total++;
      if ({bus.mem_waddr, bus.mem_wdata, bus.mem_wmode} !== {32'h100, 32'hDEAD, M_WORD}) begin
        bad++; $display("FAIL store_fields%0d got=%h/%h/%0d want=100/dead/%0d", c, bus.mem_waddr, bus.mem_wdata, bus.mem_wmode, M_WORD);
      end
      if (c < 2) tick();
    end
    tick();
    bus.mem_wready = 1'b1;
    tick();
    bus.mem_wready = 1'b0;
    o = snap();
    x = mk(2'b01, 2'b01, 0, 5, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL store_retire got=%h want=%h", o, x); end
    tick();
    o = snap();
    total++;
    if (o !== '0) begin bad++; $display("FAIL store_after got=%h want=0", o); end
  endtask

  task automatic test_speculative();
    obs_t o, x;
    put(0, 6, S_EXECUTED, U_ALU, 3, 32'h66);
    buf_m[0].speculative_tag = 6'b000001;
    push();
    bus.mem_wready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      o = snap();
      total++;
      if (o !== '0) begin bad++; $display("FAIL spec_stall%0d got=%h want=0", c, o); end
    end
    buf_m[0].speculative_tag = '0;
    push();
    tick();
    o = snap();
    x = mk(2'b01, 2'b00, 0, 6, 2'b01, 0, 3, 32'h0, 32'h66, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL spec_resolved got=%h want=%h", o, x); end
    clear_buf();
    bus.mem_wready = 1'b0;
  endtask

  task automatic test_duplicate();
    obs_t o, x;
    put(0, 7, S_EXECUTED, U_ALU, 4, 32'h77);
    put(1, 7, S_EXECUTED, U_ALU, 4, 32'h77);
    tick();
    o = snap();
    total++;
    if (o !== '0) begin bad++; $display("FAIL dup_tag got=%h want=0", o); end
    buf_m[1] = '0;
    push();
    tick();
    o = snap();
    x = mk(2'b01, 2'b00, 0, 7, 2'b01, 0, 4, 32'h0, 32'h77, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL dup_resolved got=%h want=%h", o, x); end
    clear_buf();
  endtask

  task automatic test_wrap();
    obs_t o, x;
    for (int t = 8; t < 30; t += 2) begin
      put(0, t, S_EXECUTED, U_ALU, t, 32'(t));
      put(1, t + 1, S_EXECUTED, U_LOAD, t + 1, 32'(t + 1));
      tick();
      o = snap();
      x = mk(2'b11, 2'b00, t + 1, t, 2'b11, t + 1, t, 32'(t + 1), 32'(t), 1'b0);
      total++;
      if (o !== x) begin bad++; $display("FAIL pair_%0d got=%h want=%h", t, o, x); end
      clear_buf();
    end
    put(0, 30, S_EXECUTED, U_ALU, 30, 32'h30);
    tick();
    clear_buf();
    put(0, 31, S_EXECUTED, U_ALU, 1, 32'h31);
    put(1, 1, S_EXECUTED, U_ALU, 2, 32'h1);
    tick();
    o = snap();
    x = mk(2'b11, 2'b00, 1, 31, 2'b11, 2, 1, 32'h1, 32'h31, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL wrap_pair got=%h want=%h", o, x); end
    clear_buf();
    put(0, 2, S_EXECUTED, U_ALU, 0, 32'h2);
    tick();
    o = snap();
    x = mk(2'b01, 2'b00, 0, 2, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL wrap_head2_dest0 got=%h want=%h", o, x); end
    clear_buf();
  endtask

  task automatic test_reset_mid_store();
    obs_t o, x;
    put(0, 3, S_EXECUTED, U_STORE, 0, 32'h0);
    buf_m[0].A = 32'h200;
    buf_m[0].Vk = 32'hBEEF;
    buf_m[0].rwmm = M_HALF;
    push();
    bus.mem_wready = 1'b0;
    tick();
    total++;
    if (bus.mem_wvalid !== 1'b1) begin bad++; $display("FAIL rst_store_pending got=%b want=1", bus.mem_wvalid); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata} !== '0) begin
      bad++; $display("FAIL rst_async_drop got=%b/%h/%h want=0", bus.mem_wvalid, bus.mem_waddr, bus.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_buf();
    put(0, 1, S_EXECUTED, U_ALU, 10, 32'h10);
    bus.mem_wready = 1'b1;
    tick();
    o = snap();
    x = mk(2'b01, 2'b00, 0, 1, 2'b01, 0, 10, 32'h0, 32'h10, 1'b0);
    total++;
    if (o !== x) begin bad++; $display("FAIL rst_head_one got=%h want=%h", o, x); end
    clear_buf();
    bus.mem_wready = 1'b0;
  endtask

  task automatic test_random();
    int head = 1;
    int nalloc = 1;
    bit waiting = 0;
    logic [31:0] la = '0, lv = '0;
    ldst_mode lm = M_BYTE;
    obs_t o, x;
    reset = 1'b0;
    clear_buf();
    bus.mem_wready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int live = 0;
      int j0, j1, t0, t1, a0, a1;
      logic [1:0] rc, st, we;
      logic [31:0] d0, d1;
      for (int i = 0; i < BUF_SIZE; i++)
        if (buf_m[i].tag != 0) begin
          live++;
          if (buf_m[i].e_state != S_EXECUTED && $urandom_range(2) == 0) buf_m[i].e_state = state'(buf_m[i].e_state + 1);
          if (buf_m[i].speculative_tag != 0 && $urandom_range(3) == 0) buf_m[i].speculative_tag = '0;
        end
      if (live < 12 && $urandom_range(1) == 1)
        for (int i = 0; i < BUF_SIZE; i++)
          if (buf_m[i].tag == 0) begin
            buf_m[i].tag = tag_t'(nalloc);
            buf_m[i].e_state = state'($urandom_range(3, 1));
            buf_m[i].speculative_tag = ($urandom_range(4) == 0) ? 6'd1 : 6'd0;
            buf_m[i].Unit = unit'($urandom_range(3));
            buf_m[i].ex = ex_mode'($urandom_range(3));
            buf_m[i].Dest = 5'($urandom_range(31));
            buf_m[i].result = $urandom;
            buf_m[i].A = $urandom;
            buf_m[i].Vk = $urandom;
            buf_m[i].rwmm = ldst_mode'($urandom_range(4));
            nalloc = wrap(nalloc + 1);
            break;
          end
      bus.mem_wready = ($urandom_range(2) == 0);
      push();
      rc = 0; st = 0; we = 0; t0 = 0; t1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      if (waiting) begin
        if (bus.mem_wready) begin
          rc = 2'b01;
          st = 2'b01;
          t0 = head;
          for (int i = 0; i < BUF_SIZE; i++) if (buf_m[i].tag == tag_t'(head)) buf_m[i] = '0;
          head = wrap(head + 1);
          waiting = 0;
        end
      end else begin
        j0 = find(head);
        if (j0 >= 0 && buf_m[j0].Unit == U_STORE) begin
          waiting = 1;
          la = buf_m[j0].A;
          lv = buf_m[j0].Vk;
          lm = buf_m[j0].rwmm;
        end else if (j0 >= 0) begin
          rc[0] = 1;
          t0 = head;
          if (buf_m[j0].Dest != 0 && (buf_m[j0].Unit == U_ALU || buf_m[j0].Unit == U_LOAD)) begin
            we[0] = 1; a0 = buf_m[j0].Dest; d0 = buf_m[j0].result;
          end
          j1 = find(wrap(head + 1));
          if (j1 >= 0 && buf_m[j1].Unit != U_STORE) begin
            rc[1] = 1;
            t1 = wrap(head + 1);
            if (buf_m[j1].Dest != 0 && (buf_m[j1].Unit == U_ALU || buf_m[j1].Unit == U_LOAD)) begin
              we[1] = 1; a1 = buf_m[j1].Dest; d1 = buf_m[j1].result;
            end
            buf_m[j1] = '0;
          end
          buf_m[j0] = '0;
          head = wrap(head + (rc[1] ? 2 : 1));
        end
      end
      x = mk(rc, st, t1, t0, we, a1, a0, d1, d0, waiting);
      tick();
      o = snap();
      total++;
      if (o !== x) begin bad++; $display("FAIL rand_c%0d got=%h want=%h", cyc, o, x); end
      if (waiting) begin
        total++;
        if ({bus.mem_waddr, bus.mem_wdata, bus.mem_wmode} !== {la, lv, lm}) begin
          bad++; $display("FAIL rand_store_c%0d got=%h/%h/%0d want=%h/%h/%0d", cyc, bus.mem_waddr, bus.mem_wdata, bus.mem_wmode, la, lv, lm);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_alu();
    test_partial();
    test_store();
    test_speculative();
    test_duplicate();
    test_wrap();
    test_reset_mid_store();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
